// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, load scoreboard and reset-clear sequencer
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        busy_o,
  input  logic [DATA_W-1:0]        pc_i,
  input  logic                     wa_en_i,
  input  logic [ADDR_W-1:0]        wa_addr_i,
  input  logic [DATA_W-1:0]        wa_data_i,
  input  logic                     wb_en_i,
  input  logic [ADDR_W-1:0]        wb_addr_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  input  logic                     busy_set_i,
  input  logic [ADDR_W-1:0]        busy_set_addr_i,
  output logic                     ready_o
);
  localparam int PC_IDX = 2**ADDR_W - 1;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(PC_IDX - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [DATA_W-1:0]   mem_q [PC_IDX];
  logic [PC_IDX-1:0]   busy_q;
  logic                ready_q;
  logic                run;
  assign run = state_q == RUN;
  assign ready_o = ready_q;
  // Clear sequencer, storage writes (port A applied last so it wins) and scoreboard (set applied last so it wins)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= '0;
      ready_q   <= 1'b0;
    end else if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
      clr_cnt_q        <= clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_A) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end else begin
      if (wb_en_i && wb_addr_i != PC_A) begin
        mem_q[wb_addr_i]  <= wb_data_i;
        busy_q[wb_addr_i] <= 1'b0;
      end
      if (wa_en_i && wa_addr_i != PC_A) mem_q[wa_addr_i] <= wa_data_i;
      if (busy_set_i && busy_set_addr_i != PC_A) busy_q[busy_set_addr_i] <= 1'b1;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : gen_rd
    logic [ADDR_W-1:0] a;
    logic pc_hit, wa_hit, wb_hit;
    assign a      = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign pc_hit = a == PC_A;
    assign wa_hit = run && wa_en_i && wa_addr_i == a;
    assign wb_hit = run && wb_en_i && wb_addr_i == a;
    assign rd_data_o[k*DATA_W +: DATA_W] = pc_hit ? pc_i : !run ? '0 : wa_hit ? wa_data_i :
                                           wb_hit ? wb_data_i : mem_q[a];
    assign busy_o[k] = run && !pc_hit && !wb_hit && busy_q[a];
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the processor datapath. It is the successor to the single-write, two-read register file. It adds configurable width, depth and read-port count, plus a second write port for load writeback and same-cycle write-to-read bypass. It also adds a per-register busy scoreboard for outstanding loads and a reset-clear sequencer that zeroes storage one entry per cycle. The top index is the PC alias, supplied externally.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register address width; PC_IDX = 2**ADDR_W-1 (15 by default)
NUM_RD, 3, number of read ports

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
busy_o  out  NUM_RD  port k reads a register with an outstanding load
pc_i  in  DATA_W  value returned for reads of PC_IDX
wa_en_i  in  1  ALU write enable (port A)
wa_addr_i  in  ADDR_W  port A address
wa_data_i  in  DATA_W  port A data
wb_en_i  in  1  load writeback enable (port B)
wb_addr_i  in  ADDR_W  port B address
wb_data_i  in  DATA_W  port B data
busy_set_i  in  1  mark busy_set_addr_i as pending load
busy_set_addr_i  in  ADDR_W  register to mark busy
ready_o  out  1  clear sequence done; file usable

Behaviour:
- Storage: PC_IDX entries, indices 0..PC_IDX-1. There is no storage for PC_IDX.
- FSM states are CLEAR and RUN.
- Reset:
  - rst_i high at a clock edge enters CLEAR, sets clr_cnt to 0, clears all busy bits and sets ready_o to 0.
  - Reset asserted mid-CLEAR or mid-RUN restarts the sequence from index 0.
- CLEAR:
  - Each cycle writes 0 to entry clr_cnt, then increments clr_cnt.
  - When clr_cnt = PC_IDX-1 is written, the next state is RUN.
  - ready_o goes to 1 on the edge entering RUN. For the default parameters that is the 15th edge after the last reset edge.
  - During CLEAR, wa_en_i, wb_en_i and busy_set_i are ignored.
  - During CLEAR, rd_data_o reads 0 for non-PC addresses and pc_i for PC_IDX. busy_o is all 0.
- RUN writes (posedge):
  - wa_en_i writes wa_data_i to entry wa_addr_i.
  - wb_en_i writes wb_data_i to entry wb_addr_i.
  - If both ports target the same address in the same cycle, port A wins.
  - Writes to PC_IDX are dropped.
- Reads are combinational, with this priority per port:
  1. addr = PC_IDX: return pc_i.
  2. wa_en_i and wa_addr_i = addr: return wa_data_i.
  3. wb_en_i and wb_addr_i = addr: return wb_data_i.
  4. Otherwise return the stored entry.
- Scoreboard (one busy bit per storage entry):
  - busy_set_i sets busy[busy_set_addr_i]; a set on PC_IDX is ignored.
  - A wb_en_i write clears busy[wb_addr_i]. A wa_en_i write does not clear busy.
  - If a set and a clear hit the same address in the same cycle, set wins (a new load has issued).
  - busy_o[k] = busy[rd_addr_k] AND NOT (wb_en_i AND wb_addr_i = rd_addr_k). A register being written back this cycle is forwarded, so it is not reported busy.
  - busy_o[k] is always 0 when rd_addr_k = PC_IDX or the FSM is in CLEAR.
- There is no read latency. Write-to-storage latency is 1 edge; bypass makes write data visible in the same cycle.

Test Plan:
- Reset clear: preload r3 = 0xDEADBEEF, pulse rst_i for 1 cycle -> ready_o is 0 for 15 cycles then 1; reading r3 returns 0x00000000. A wa write to r3 issued during CLEAR is lost.
- Basic and PC read: write r5 = 0x12345678 via port A, then read r5 on port 0 and r15 on port 1 with pc_i = 0x00000040 -> 0x12345678 and 0x00000040. A port A write to r15 leaves r15 reads at pc_i.
- Bypass and port priority: in one cycle set wa r7 = 0x1, wb r7 = 0x2, read r7 -> 0x1 same cycle; 0x1 stored after the edge. wb-only write of r8 = 0xAA reads 0xAA in the same cycle.
- Scoreboard: busy_set r4, next cycle read r4 -> busy_o = 1. Assert wb_en r4 = 0x55 -> busy_o = 0 and data 0x55 that cycle; busy stays 0 afterwards. busy_set r4 together with wb_en r4 in the same cycle -> r4 busy the next cycle.
- Mid-operation reset: with r2 busy and the FSM in RUN, assert rst_i -> busy_o = 0 and ready_o = 0; the clear restarts and completes after 15 cycles. Reset asserted at cycle 7 of CLEAR -> ready_o rises 15 cycles after that reset edge.
